sd_dat_card_responder: RTL and testbench

- Synthesizable SD-card-side model of the 4-bit DAT bus. It is the card end of the host DAT block.
- Write direction: receives host write blocks, checks per-line CRC16 and end bit, returns the CRC status token, then holds busy.
- Read direction: on request, sources block_cnt read blocks of a deterministic byte pattern with per-line CRC16.
- Sits on the sd_clk domain and replaces the open-loop DAT_din stimulus in DAT-level benches.

---
 rtl/sd_dat_card_responder_pkg.sv | 17 +
 rtl/sd_dat_card_responder_crc16.sv | 22 ++
 rtl/sd_dat_card_responder.sv | 183 ++++++++++++++++++
 tb/tb_sd_dat_card_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_dat_card_responder_pkg.sv
// sd_dat_card_responder_pkg
//   Shared widths, CRC status token values and the FSM state encoding for the
//   SD card-side DAT bus responder.
package sd_dat_card_responder_pkg;

  localparam int BLOCK_SZ_WIDTH  = 10;
  localparam int BLOCK_CNT_WIDTH = 8;

  localparam logic [2:0] CRC_STAT_OK  = 3'b010;
  localparam logic [2:0] CRC_STAT_ERR = 3'b101;

  typedef enum logic [3:0] {
    IDLE, WR_DATA, WR_CRC, WR_END, WR_GAP, WR_TOKEN, WR_BUSY,
    RD_GAP, RD_START, RD_DATA, RD_CRC, RD_END
  } dat_state_e;

endpackage

// File: rtl/sd_dat_card_responder_crc16.sv
// sd_crc16_serial
//   Bit-serial CRC16 (x^16+x^12+x^5+1), init 0, MSB first.
//   Ports: clk, rst_L (sync, active low), clr (sync clear), en (absorb din),
//          din (data bit), crc (current remainder).
//   Feeding din = crc[15] makes the feedback zero, so the register simply
//   shifts left; the responder uses that to stream the CRC out MSB first.
module sd_crc16_serial (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic fb;
  assign fb = din ^ crc[15];

  always_ff @(posedge clk) begin
    if (!rst_L || clr) crc <= '0;
    else if (en)       crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end
endmodule

// File: rtl/sd_dat_card_responder.sv
// sd_dat_card_responder
//   Card end of a 4-bit SD DAT bus, on the sd_clk domain.
//   Write: start bit -> 2*block_sz nibbles -> 16 CRC nibbles -> end bit,
//          then gap, CRC status token on DAT0 and a busy phase.
//   Read : on rd_start, block_cnt blocks of an incrementing byte pattern,
//          each with per-line CRC16 and end bit.
//   Ports: sd_clk, rst_L (sync active low), DAT_din (host lines),
//          DAT_dout/DAT_oe (card drive), block_sz, block_cnt, wr_en,
//          rd_start, rd_seed, rx_byte/rx_byte_valid (write bytes),
//          busy (not IDLE), wr_ok_cnt / wr_err_cnt (token counters).
module sd_dat_card_responder
  import sd_dat_card_responder_pkg::*;
#(
  parameter int BUSY_CYCLES = 8,
  parameter int NCRC_GAP    = 2,
  parameter int NAC_GAP     = 2
) (
  input  logic                       sd_clk,
  input  logic                       rst_L,
  input  logic [3:0]                 DAT_din,
  output logic [3:0]                 DAT_dout,
  output logic                       DAT_oe,
  input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
  input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
  input  logic                       wr_en,
  input  logic                       rd_start,
  input  logic [7:0]                 rd_seed,
  output logic [7:0]                 rx_byte,
  output logic                       rx_byte_valid,
  output logic                       busy,
  output logic [15:0]                wr_ok_cnt,
  output logic [15:0]                wr_err_cnt
);
  // Counter must reach 2*block_sz-1, 15 and BUSY_CYCLES.
  localparam int CW = BLOCK_SZ_WIDTH + 2;

  dat_state_e                 state;
  logic [CW-1:0]              cnt, last_nib;
  logic [BLOCK_SZ_WIDTH-1:0]  sz;
  logic [BLOCK_CNT_WIDTH-1:0] rem;
  logic [7:0]                 rd_byte;
  logic [3:0]                 hi_nib;
  logic                       crc_bad;
  logic [2:0]                 status;

  logic [3:0][15:0] crc;
  logic [3:0]       crc_msb, crc_din, rd_nib;
  logic             crc_en, crc_clr;

  assign last_nib = {1'b0, sz, 1'b0} - CW'(1);
  assign crc_msb  = {crc[3][15], crc[2][15], crc[1][15], crc[0][15]};
  // Next read nibble: high nibble at even positions, low nibble at odd ones.
  assign rd_nib   = (state == RD_START || cnt[0]) ? rd_byte[7:4] : rd_byte[3:0];
  assign crc_clr  = (state == IDLE) || (state == RD_GAP);

  // CRC absorbs each read nibble on the same edge that registers it onto
  // DAT_dout, so the remainder is complete when the CRC phase begins.
  always_comb begin
    crc_en  = 1'b0;
    crc_din = crc_msb;
    case (state)
      WR_DATA:  begin crc_en = 1'b1; crc_din = DAT_din; end
      WR_CRC:   crc_en = 1'b1;
      RD_START: begin crc_en = 1'b1; if (sz != '0) crc_din = rd_nib; end
      RD_DATA:  begin crc_en = 1'b1; if (cnt != last_nib) crc_din = rd_nib; end
      RD_CRC:   crc_en = (cnt != CW'(15));
      default:  ;
    endcase
  end

  sd_crc16_serial u_crc [3:0] (
    .clk   (sd_clk),
    .rst_L (rst_L),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  always_ff @(posedge sd_clk) begin
    if (!rst_L) begin
      state <= IDLE;   cnt <= '0;     sz <= '0;      rem <= '0;
      rd_byte <= '0;   hi_nib <= '0;  crc_bad <= 1'b0; status <= '0;
      DAT_oe <= 1'b0;  DAT_dout <= 4'hF;
      rx_byte <= '0;   rx_byte_valid <= 1'b0; busy <= 1'b0;
      wr_ok_cnt <= '0; wr_err_cnt <= '0;
    end else begin
      rx_byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          DAT_oe <= 1'b0; DAT_dout <= 4'hF; cnt <= '0;
          if (rd_start) begin
            sz      <= block_sz;
            rem     <= (block_cnt == '0) ? BLOCK_CNT_WIDTH'(1) : block_cnt;
            rd_byte <= rd_seed;
            busy    <= 1'b1;
            state   <= RD_GAP;
          end else if (wr_en && DAT_din == 4'h0) begin
            sz      <= block_sz;
            crc_bad <= 1'b0;
            busy    <= 1'b1;
            state   <= (block_sz == '0) ? WR_CRC : WR_DATA;
          end
        end
        WR_DATA: begin
          cnt <= cnt + CW'(1);
          if (!cnt[0]) hi_nib <= DAT_din;
          else begin rx_byte <= {hi_nib, DAT_din}; rx_byte_valid <= 1'b1; end
          if (cnt == last_nib) begin cnt <= '0; state <= WR_CRC; end
        end
        WR_CRC: begin
          cnt     <= cnt + CW'(1);
          crc_bad <= crc_bad | (DAT_din != crc_msb);
          if (cnt == CW'(15)) begin cnt <= '0; state <= WR_END; end
        end
        WR_END: begin
          status <= (!crc_bad && DAT_din == 4'hF) ? CRC_STAT_OK : CRC_STAT_ERR;
          cnt    <= '0;
          state  <= WR_GAP;
        end
        WR_GAP: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NCRC_GAP - 1)) begin
            cnt <= '0; state <= WR_TOKEN; DAT_oe <= 1'b1; DAT_dout <= 4'hE;
          end
        end
        WR_TOKEN: begin
          cnt <= cnt + CW'(1);
          case (cnt)
            CW'(0): DAT_dout <= {3'b111, status[2]};
            CW'(1): DAT_dout <= {3'b111, status[1]};
            CW'(2): DAT_dout <= {3'b111, status[0]};
            CW'(3): begin
              DAT_dout <= 4'hF;
              if (status == CRC_STAT_OK) wr_ok_cnt  <= wr_ok_cnt + 16'd1;
              else                       wr_err_cnt <= wr_err_cnt + 16'd1;
            end
            default: begin cnt <= '0; DAT_dout <= 4'hE; state <= WR_BUSY; end
          endcase
        end
        WR_BUSY: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(BUSY_CYCLES - 1)) DAT_dout <= 4'hF;
          if (cnt == CW'(BUSY_CYCLES)) begin
            DAT_oe <= 1'b0; busy <= 1'b0; state <= IDLE;
          end
        end
        RD_GAP: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NAC_GAP - 1)) begin
            cnt <= '0; state <= RD_START; DAT_oe <= 1'b1; DAT_dout <= 4'h0;
          end
        end
        RD_START: begin
          cnt <= '0;
          if (sz == '0) begin DAT_dout <= crc_msb; state <= RD_CRC;  end
          else          begin DAT_dout <= rd_nib;  state <= RD_DATA; end
        end
        RD_DATA: begin
          cnt <= cnt + CW'(1);
          if (cnt == last_nib) begin
            cnt <= '0; DAT_dout <= crc_msb; state <= RD_CRC;
          end else begin
            DAT_dout <= rd_nib;
            if (!cnt[0]) rd_byte <= rd_byte + 8'd1;  // low nibble leaves now
          end
        end
        RD_CRC: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(15)) begin DAT_dout <= 4'hF; state <= RD_END; end
          else DAT_dout <= crc_msb;
        end
        RD_END: begin
          DAT_oe <= 1'b0;
          cnt    <= '0;
          if (rem == BLOCK_CNT_WIDTH'(1)) begin state <= IDLE; busy <= 1'b0; end
          else begin rem <= rem - BLOCK_CNT_WIDTH'(1); state <= RD_GAP; end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_dat_card_responder.sv
// tb_sd_dat_card_responder
//   Randomized and directed stimulus for the card-side DAT responder, checked
//   against a reference built from the bus rules: CRCs by polynomial long
//   division, expected per-cycle {oe,dout} traces from the transfer framing.
module tb_sd_dat_card_responder;
  import sd_dat_card_responder_pkg::*;

  localparam int BUSY = 8;
  localparam int NCRC = 2;
  localparam int NAC  = 2;

  logic                       sd_clk = 1'b0;
  logic                       rst_L  = 1'b0;
  logic [3:0]                 DAT_din = 4'hF;
  logic [3:0]                 DAT_dout;
  logic                       DAT_oe;
  logic [BLOCK_SZ_WIDTH-1:0]  block_sz = '0;
  logic [BLOCK_CNT_WIDTH-1:0] block_cnt = '0;
  logic                       wr_en = 1'b0;
  logic                       rd_start = 1'b0;
  logic [7:0]                 rd_seed = '0;
  logic [7:0]                 rx_byte;
  logic                       rx_byte_valid;
  logic                       busy;
  logic [15:0]                wr_ok_cnt, wr_err_cnt;

  always #5 sd_clk = ~sd_clk;

  sd_dat_card_responder #(.BUSY_CYCLES(BUSY), .NCRC_GAP(NCRC), .NAC_GAP(NAC)) dut (
    .sd_clk(sd_clk), .rst_L(rst_L), .DAT_din(DAT_din), .DAT_dout(DAT_dout),
    .DAT_oe(DAT_oe), .block_sz(block_sz), .block_cnt(block_cnt), .wr_en(wr_en),
    .rd_start(rd_start), .rd_seed(rd_seed), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .busy(busy), .wr_ok_cnt(wr_ok_cnt),
    .wr_err_cnt(wr_err_cnt)
  );

  int          n_chk = 0, n_err = 0;
  logic [7:0]  msg[$], got[$];
  logic [4:0]  tr[$], ex[$];
  logic [15:0] exp_ok = '0, exp_err = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge sd_clk); #1;
    if (rx_byte_valid) got.push_back(rx_byte);
  endtask

  // CRC16 of one DAT line's bit stream (nibble high first), as the
  // remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] ref_crc(input int line);
    logic [16:0] r;
    logic        bb;
    r = '0;
    foreach (msg[i])
      for (int h = 0; h < 2; h++) begin
        bb = (h == 0) ? msg[i][4+line] : msg[i][line];
        r = {r[15:0], bb};
        if (r[16]) r = r ^ 17'h11021;
      end
    for (int z = 0; z < 16; z++) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic capture(input int n, input int pulse_at);
    tr.delete();
    for (int i = 0; i < n; i++) begin
      tr.push_back({DAT_oe, DAT_dout});
      rd_start = (i == pulse_at);
      tick();
    end
    rd_start = 1'b0;
  endtask

  // Where the card should not drive, only oe is compared.
  task automatic cmp_trace(input string tag);
    for (int i = 0; i < ex.size(); i++)
      if (ex[i][4]) chk(tag, 32'(tr[i]), 32'(ex[i]));
      else          chk(tag, 32'(tr[i][4]), 32'd0);
  endtask

  // Host write of msg[] with optional CRC-bit flips per line and end nibble.
  task automatic host_write(input logic [3:0] flip, input logic [3:0] endn, input int pulse_at);
    logic [3:0][15:0] c;
    logic [2:0]       st;
    bit               good;
    for (int l = 0; l < 4; l++) c[l] = ref_crc(l) ^ {15'b0, flip[l]};
    good = (flip == 4'h0) && (endn == 4'hF);
    st   = good ? 3'b010 : 3'b101;
    got.delete();
    block_sz = BLOCK_SZ_WIDTH'(msg.size());
    wr_en = 1'b1; DAT_din = 4'h0; tick();
    chk("busy_wr", 32'(busy), 32'd1);
    foreach (msg[i]) begin
      DAT_din = msg[i][7:4]; tick();
      DAT_din = msg[i][3:0]; tick();
    end
    for (int k = 15; k >= 0; k--) begin
      DAT_din = {c[3][k], c[2][k], c[1][k], c[0][k]}; tick();
    end
    DAT_din = endn; tick();
    DAT_din = 4'hF;
    ex.delete();
    repeat (NCRC) ex.push_back(5'h0F);
    ex.push_back(5'h1E);
    for (int j = 2; j >= 0; j--) ex.push_back({4'b1111, st[j]});
    ex.push_back(5'h1F);
    repeat (BUSY) ex.push_back(5'h1E);
    ex.push_back(5'h1F);
    repeat (3) ex.push_back(5'h0F);
    capture(ex.size(), pulse_at);
    cmp_trace("wr_trace");
    if (good) exp_ok = exp_ok + 16'd1; else exp_err = exp_err + 16'd1;
    chk("wr_ok_cnt", 32'(wr_ok_cnt), 32'(exp_ok));
    chk("wr_err_cnt", 32'(wr_err_cnt), 32'(exp_err));
    chk("busy_end", 32'(busy), 32'd0);
    chk("rx_count", 32'(got.size()), 32'(msg.size()));
    for (int i = 0; i < msg.size() && i < got.size(); i++)
      chk("rx_byte", 32'(got[i]), 32'(msg[i]));
  endtask

  task automatic host_read(input int sz, input int cnt, input logic [7:0] seed, input bit with_wr);
    logic [3:0][15:0] c;
    logic [7:0]       b;
    int               nb;
    got.delete();
    block_sz = BLOCK_SZ_WIDTH'(sz); block_cnt = BLOCK_CNT_WIDTH'(cnt); rd_seed = seed;
    rd_start = 1'b1;
    if (with_wr) begin wr_en = 1'b1; DAT_din = 4'h0; end
    tick();
    rd_start = 1'b0; DAT_din = 4'hF;
    nb = (cnt == 0) ? 1 : cnt;
    b  = seed;
    ex.delete();
    for (int k = 0; k < nb; k++) begin
      repeat (NAC) ex.push_back(5'h0F);
      ex.push_back(5'h10);
      msg.delete();
      for (int i = 0; i < sz; i++) begin
        msg.push_back(b);
        ex.push_back({1'b1, b[7:4]});
        ex.push_back({1'b1, b[3:0]});
        b = b + 8'd1;
      end
      for (int l = 0; l < 4; l++) c[l] = ref_crc(l);
      for (int j = 15; j >= 0; j--) ex.push_back({1'b1, c[3][j], c[2][j], c[1][j], c[0][j]});
      ex.push_back(5'h1F);
    end
    repeat (4) ex.push_back(5'h0F);
    capture(ex.size(), -1);
    cmp_trace("rd_trace");
    chk("rd_busy_end", 32'(busy), 32'd0);
    chk("rd_no_rx", 32'(got.size()), 32'd0);
    chk("rd_ok_cnt", 32'(wr_ok_cnt), 32'(exp_ok));
    chk("rd_err_cnt", 32'(wr_err_cnt), 32'(exp_err));
  endtask

  task automatic load_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_oe", 32'(DAT_oe), 32'd0);
    chk("rst_dout", 32'(DAT_dout), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx", 32'({rx_byte, rx_byte_valid}), 32'd0);
    chk("rst_cnts", 32'({wr_ok_cnt, wr_err_cnt}), 32'd0);
    rst_L = 1'b1; tick();

    // partial start pattern and disabled write are ignored
    wr_en = 1'b1; DAT_din = 4'h8; tick();
    chk("partial_start", 32'(busy), 32'd0);
    wr_en = 1'b0; DAT_din = 4'h0; tick();
    chk("wr_disabled", 32'(busy), 32'd0);
    DAT_din = 4'hF; tick();

    // good, bad-CRC, bad-end writes
    msg = '{8'h12, 8'h34, 8'h56, 8'h78};
    host_write(4'h0, 4'hF, -1);
    host_write(4'b0100, 4'hF, -1);
    host_write(4'h0, 4'hE, -1);

    // multi-block read
    host_read(4, 2, 8'hA0, 1'b0);

    // read wins over a coincident write start
    host_read(2, 1, 8'($urandom), 1'b1);

    // rd_start during busy is ignored
    load_msg(3);
    host_write(4'h0, 4'hF, NCRC + 5 + 3);
    ex.delete(); repeat (10) ex.push_back(5'h0F);
    capture(10, -1);
    cmp_trace("busy_rd_ignored");

    // reset in the middle of a write
    load_msg(4);
    wr_en = 1'b1; DAT_din = 4'h0; tick();
    DAT_din = msg[0][7:4]; tick();
    DAT_din = msg[0][3:0]; tick();
    DAT_din = msg[1][7:4]; tick();
    rst_L = 1'b0; tick();
    chk("mid_rst_oe", 32'(DAT_oe), 32'd0);
    chk("mid_rst_dout", 32'(DAT_dout), 32'hF);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnts", 32'({wr_ok_cnt, wr_err_cnt}), 32'd0);
    chk("mid_rst_rxv", 32'(rx_byte_valid), 32'd0);
    rst_L = 1'b1; DAT_din = 4'hF;
    exp_ok = '0; exp_err = '0;
    ex.delete(); repeat (25) ex.push_back(5'h0F);
    capture(25, -1);
    cmp_trace("no_token_after_rst");
    host_write(4'h0, 4'hF, -1);

    // randomized mix of writes and reads
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [3:0] fl, en;
        load_msg($urandom_range(0, 6));
        fl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        en = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        host_write(fl, en, -1);
      end else begin
        host_read($urandom_range(0, 5), $urandom_range(0, 3), 8'($urandom), 1'b0);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
